qed_subseq_cmp: RTL and testbench

QED_SUBSEQ_CMP -- requirements
Module: qed_subseq_cmp

---
 rtl/qed_subseq_cmp.sv | 194 +++++++++++++++++++
 tb/tb_qed_subseq_cmp.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_subseq_cmp.sv
// Captures one target subsequence from each of two design copies and
// compares them beat by beat, reporting length, overflow and first mismatch.
module qed_subseq_cmp #(
   parameter int  DW    = 24,
   parameter int  CH    = 6,
   parameter int  DEPTH = 32,
   parameter int  CW    = 16,
   parameter int  LAT   = 5,
   localparam int AW    = $clog2(DEPTH),
   localparam int BW    = CH * DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] idx_a,
   input  logic [CW-1:0] idx_b,
   input  logic          halt_a,
   input  logic          halt_b,
   input  logic          valid_a,
   input  logic          valid_b,
   input  logic [BW-1:0] data_a,
   input  logic [BW-1:0] data_b,
   output logic          busy,
   output logic          done,
   output logic          match,
   output logic [AW:0]   len_a,
   output logic [AW:0]   len_b,
   output logic          ovf,
   output logic [AW-1:0] diff_idx
);

   typedef enum logic [1:0] {S_IDLE, S_CAP, S_CMP, S_RES} state_t;

   state_t        state_q, state_d;
   logic [LAT:0]  hsr_q [2];
   logic [LAT:0]  hsr_d [2];
   logic [CW-1:0] seq_q [2];
   logic [CW-1:0] seq_d [2];
   logic [CW-1:0] tgt_q [2];
   logic [CW-1:0] tgt_d [2];
   logic [AW:0]   len_q [2];
   logic [AW:0]   len_d [2];
   logic [1:0]    closed_q, closed_d;
   logic          ovf_q, ovf_d;
   logic          match_q, match_d;
   logic [AW-1:0] p_q, p_d;
   logic [AW-1:0] diff_q, diff_d;

   logic [BW-1:0] mem_a [DEPTH];
   logic [BW-1:0] mem_b [DEPTH];

   logic [1:0]    hin, vin, dl, bnd, hit, cap, we, cls;
   logic [AW:0]   p_nxt;
   logic [AW-1:0] len_min;
   logic          cap_st, busy_st;

   assign hin     = {halt_b, halt_a};
   assign vin     = {valid_b, valid_a};
   assign cap_st  = (state_q == S_CAP);
   assign busy_st = (state_q == S_CAP) || (state_q == S_CMP);

   always_comb begin
      state_d  = state_q;
      hsr_d    = hsr_q;
      seq_d    = seq_q;
      tgt_d    = tgt_q;
      len_d    = len_q;
      closed_d = closed_q;
      ovf_d    = ovf_q;
      p_d      = p_q;
      match_d  = match_q;
      diff_d   = diff_q;
      dl       = '0;
      bnd      = '0;
      hit      = '0;
      cap      = '0;
      we       = '0;
      cls      = '0;
      p_nxt    = {1'b0, p_q} + (AW+1)'(1);
      len_min  = (len_q[0] < len_q[1]) ? len_q[0][AW-1:0]
                                       : len_q[1][AW-1:0];

      for (int c = 0; c < 2; c++) begin
         hsr_d[c] = {hsr_q[c][LAT-1:0], hin[c]};
         dl[c]    = hsr_q[c][LAT-1];
         bnd[c]   = dl[c] & ~hsr_q[c][LAT];
         hit[c]   = (seq_q[c] == tgt_q[c]);
         cap[c]   = cap_st & vin[c] & ~dl[c] & hit[c]
                  & ~closed_q[c] & ~start;
         we[c]    = cap[c] & ~len_q[c][AW];
         cls[c]   = cap_st & bnd[c] & hit[c] & ~closed_q[c];
         if (busy_st && bnd[c] && !(&seq_q[c]))
            seq_d[c] = seq_q[c] + CW'(1);
         if (we[c])
            len_d[c] = len_q[c] + (AW+1)'(1);
         // len MSB set means the buffer is already full
         if (cap[c] && len_q[c][AW])
            ovf_d = 1'b1;
         if (cls[c])
            closed_d[c] = 1'b1;
      end

      unique case (state_q)
         S_IDLE: ;
         S_CAP: begin
            if ((closed_q[0] | cls[0]) && (closed_q[1] | cls[1]))
               state_d = S_CMP;
         end
         S_CMP: begin
            if (ovf_q || (len_q[0] != len_q[1])) begin
               state_d = S_RES;
               match_d = 1'b0;
               diff_d  = len_min;
            end else if (len_q[0] == '0) begin
               state_d = S_RES;
               match_d = 1'b1;
               diff_d  = '0;
            end else if (mem_a[p_q] != mem_b[p_q]) begin
               state_d = S_RES;
               match_d = 1'b0;
               diff_d  = p_q;
            end else if (p_nxt == len_q[0]) begin
               state_d = S_RES;
               match_d = 1'b1;
               diff_d  = '0;
            end else begin
               p_d = p_q + AW'(1);
            end
         end
         S_RES: ;
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d  = S_CAP;
         tgt_d[0] = idx_a;
         tgt_d[1] = idx_b;
         seq_d[0] = '0;
         seq_d[1] = '0;
         len_d[0] = '0;
         len_d[1] = '0;
         closed_d = '0;
         ovf_d    = 1'b0;
         p_d      = '0;
         match_d  = 1'b0;
         diff_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         closed_q <= '0;
         ovf_q    <= 1'b0;
         match_q  <= 1'b0;
         p_q      <= '0;
         diff_q   <= '0;
         for (int c = 0; c < 2; c++) begin
            hsr_q[c] <= '0;
            seq_q[c] <= '0;
            tgt_q[c] <= '0;
            len_q[c] <= '0;
         end
      end else begin
         state_q  <= state_d;
         closed_q <= closed_d;
         ovf_q    <= ovf_d;
         match_q  <= match_d;
         p_q      <= p_d;
         diff_q   <= diff_d;
         for (int c = 0; c < 2; c++) begin
            hsr_q[c] <= hsr_d[c];
            seq_q[c] <= seq_d[c];
            tgt_q[c] <= tgt_d[c];
            len_q[c] <= len_d[c];
         end
      end
   end

   // capture buffers carry no reset; reads stay below len
   always_ff @(posedge clk) begin
      if (we[0]) mem_a[len_q[0][AW-1:0]] <= data_a;
      if (we[1]) mem_b[len_q[1][AW-1:0]] <= data_b;
   end

   assign busy     = busy_st;
   assign done     = (state_q == S_RES);
   assign match    = match_q;
   assign len_a    = len_q[0];
   assign len_b    = len_q[1];
   assign ovf      = ovf_q;
   assign diff_idx = diff_q;

endmodule

// File: tb/tb_qed_subseq_cmp.sv
// Randomized bench for qed_subseq_cmp with a queue-based reference model
// derived from halt boundaries and captured beat lists.
module tb_qed_subseq_cmp;

   localparam int DW    = 4;
   localparam int CH    = 6;
   localparam int DEPTH = 4;
   localparam int CW    = 8;
   localparam int LAT   = 3;
   localparam int AW    = 2;
   localparam int BW    = CH * DW;
   localparam int MAXC  = 256;
   localparam logic [BW-1:0] MUT = 24'h0F0000;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [CW-1:0] idx_a, idx_b;
   logic          halt_a, halt_b, valid_a, valid_b;
   logic [BW-1:0] data_a, data_b;
   logic          busy, done, match, ovf;
   logic [AW:0]   len_a, len_b;
   logic [AW-1:0] diff_idx;

   always #5 clk = ~clk;

   qed_subseq_cmp #(
      .DW(DW), .CH(CH), .DEPTH(DEPTH), .CW(CW), .LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .idx_a(idx_a), .idx_b(idx_b),
      .halt_a(halt_a), .halt_b(halt_b),
      .valid_a(valid_a), .valid_b(valid_b),
      .data_a(data_a), .data_b(data_b),
      .busy(busy), .done(done), .match(match),
      .len_a(len_a), .len_b(len_b),
      .ovf(ovf), .diff_idx(diff_idx)
   );

   int n_chk = 0;
   int n_err = 0;

   logic          sh [2][MAXC];
   logic          sv [2][MAXC];
   logic [BW-1:0] sd [2][MAXC];
   logic [BW-1:0] tmpl [8];
   logic [BW-1:0] qa [$];
   logic [BW-1:0] qb [$];

   int e_len [2];
   int e_ovf, e_match, e_diff, e_done_k;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      start   = 1'b0;
      halt_a  = 1'b0;
      halt_b  = 1'b0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      data_a  = '0;
      data_b  = '0;
   endtask

   task automatic new_tmpl();
      for (int i = 0; i < 8; i++) tmpl[i] = BW'($urandom);
   endtask

   // one copy's stream: idx halt-terminated subsequences, target last
   task automatic gen(int c, int idx, int nbt, int mut, bit clean);
      int k, nb, pl;
      for (int i = 0; i < MAXC; i++) begin
         sh[c][i] = 1'b0;
         sv[c][i] = 1'b0;
         sd[c][i] = '0;
      end
      k = 0;
      for (int j = 0; j <= idx; j++) begin
         nb = (j == idx) ? nbt : int'($urandom_range(0, 3));
         for (int b = 0; b < nb; b++) begin
            if (!clean) k += $urandom_range(0, 2);
            sv[c][k] = 1'b1;
            if (j == idx)
               sd[c][k] = tmpl[b] ^ ((b == mut) ? MUT : '0);
            else
               sd[c][k] = BW'($urandom);
            k++;
         end
         k += clean ? 1 : int'($urandom_range(1, 2));
         pl = clean ? 1 : int'($urandom_range(1, 2));
         for (int p = 0; p < pl; p++) begin
            sh[c][k] = 1'b1;
            k++;
         end
         k += clean ? LAT + 2 : int'($urandom_range(0, LAT + 2));
      end
   endtask

   function automatic bit hist(int c, int k);
      return (k < 0) ? 1'b0 : sh[c][k];
   endfunction

   task automatic model(int ia, int ib);
      int id [2];
      int cl [2];
      int seq, la, lb, cmax, ncmp, q;
      bit dh, dh1;
      id[0] = ia;
      id[1] = ib;
      qa.delete();
      qb.delete();
      for (int c = 0; c < 2; c++) begin
         seq   = 0;
         cl[c] = -1;
         for (int k = 0; k < MAXC && cl[c] < 0; k++) begin
            dh  = hist(c, k - LAT);
            dh1 = hist(c, k - LAT - 1);
            if (sv[c][k] && !dh && seq == id[c]) begin
               if (c == 0) qa.push_back(sd[c][k]);
               else        qb.push_back(sd[c][k]);
            end
            if (dh && !dh1) begin
               if (seq == id[c]) cl[c] = k;
               else              seq++;
            end
         end
      end
      la = (qa.size() > DEPTH) ? DEPTH : qa.size();
      lb = (qb.size() > DEPTH) ? DEPTH : qb.size();
      e_len[0] = la;
      e_len[1] = lb;
      e_ovf = (qa.size() > DEPTH || qb.size() > DEPTH) ? 1 : 0;
      cmax  = (cl[0] > cl[1]) ? cl[0] : cl[1];
      if (cl[0] < 0 || cl[1] < 0) cmax = MAXC + 100;
      if (e_ovf != 0 || la != lb) begin
         e_match = 0;
         e_diff  = ((la < lb) ? la : lb) % DEPTH;
         ncmp    = 1;
      end else if (la == 0) begin
         e_match = 1;
         e_diff  = 0;
         ncmp    = 1;
      end else begin
         q = -1;
         for (int i = 0; i < la && q < 0; i++)
            if (qa[i] != qb[i]) q = i;
         if (q >= 0) begin
            e_match = 0;
            e_diff  = q;
            ncmp    = q + 1;
         end else begin
            e_match = 1;
            e_diff  = 0;
            ncmp    = la;
         end
      end
      e_done_k = cmax + ncmp;
   endtask

   task automatic start_run(int ia, int ib);
      idle_in();
      repeat (LAT + 2) tick();
      idx_a = CW'(ia);
      idx_b = CW'(ib);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("done_after_start", done, 0);
   endtask

   // drives stream from cycle 0 after start; rst_back>0 resets mid-compare
   task automatic drive_run(int ia, int ib, int rst_back);
      int rk, got_k;
      model(ia, ib);
      rk    = (rst_back > 0) ? e_done_k - rst_back : -1;
      got_k = -1;
      for (int k = 0; k < MAXC + 40; k++) begin
         halt_a  = (k < MAXC) ? sh[0][k] : 1'b0;
         halt_b  = (k < MAXC) ? sh[1][k] : 1'b0;
         valid_a = (k < MAXC) ? sv[0][k] : 1'b0;
         valid_b = (k < MAXC) ? sv[1][k] : 1'b0;
         data_a  = (k < MAXC) ? sd[0][k] : '0;
         data_b  = (k < MAXC) ? sd[1][k] : '0;
         rst     = (k == rk);
         tick();
         if (k == rk) begin
            rst = 1'b0;
            idle_in();
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_match", match, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_len_a", len_a, 0);
            chk("rst_len_b", len_b, 0);
            chk("rst_diff", diff_idx, 0);
            repeat (3) tick();
            chk("rst_stays_idle", busy | done, 0);
            return;
         end
         if (done) begin
            got_k = k;
            break;
         end
      end
      idle_in();
      if (got_k < 0) begin
         chk("timeout_done", 0, 1);
         return;
      end
      chk("latency", got_k, e_done_k);
      chk("busy_at_done", busy, 0);
      chk("match", match, e_match);
      chk("len_a", len_a, e_len[0]);
      chk("len_b", len_b, e_len[1]);
      chk("ovf", ovf, e_ovf);
      chk("diff_idx", diff_idx, e_diff);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ia, ib, na, nb, mut;
      bit cl;
      idle_in();
      idx_a = '0;
      idx_b = '0;
      rst   = 1'b1;
      tick();
      start = 1'b1;
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_match", match, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_len_a", len_a, 0);
      chk("reset_len_b", len_b, 0);
      chk("reset_diff", diff_idx, 0);
      start = 1'b0;
      rst   = 1'b0;

      // identical 3-beat target subsequences
      new_tmpl();
      gen(0, 2, 3, -1, 1);
      gen(1, 0, 3, -1, 1);
      start_run(2, 0);
      drive_run(2, 0, 0);
      chk("d_equal_match", match, 1);
      chk("d_equal_len", len_a, 3);

      // channel 4 of beat 1 flipped on copy A
      gen(0, 2, 3, 1, 1);
      gen(1, 0, 3, -1, 1);
      start_run(2, 0);
      drive_run(2, 0, 0);
      chk("d_flip_match", match, 0);
      chk("d_flip_diff", diff_idx, 1);

      // 4 beats against 3
      gen(0, 1, 4, -1, 1);
      gen(1, 1, 3, -1, 1);
      start_run(1, 1);
      drive_run(1, 1, 0);
      chk("d_len_diff", diff_idx, 3);

      // overflow past DEPTH
      gen(0, 0, 6, -1, 1);
      gen(1, 0, 3, -1, 1);
      start_run(0, 0);
      drive_run(0, 0, 0);
      chk("d_ovf_len", len_a, 4);
      chk("d_ovf_flag", ovf, 1);
      chk("d_ovf_match", match, 0);

      for (int it = 0; it < 40; it++) begin
         new_tmpl();
         ia  = $urandom_range(0, 3);
         ib  = $urandom_range(0, 3);
         na  = $urandom_range(0, 6);
         nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : na;
         mut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
         cl  = 1'($urandom_range(0, 1));
         gen(0, ia, na, mut, cl);
         gen(1, ib, nb, -1, cl);
         start_run(ia, ib);
         drive_run(ia, ib, 0);
      end

      // abort mid-capture, then finish the restarted run
      new_tmpl();
      gen(0, 0, 3, -1, 1);
      gen(1, 0, 3, -1, 1);
      start_run(0, 0);
      for (int k = 0; k < 3; k++) begin
         valid_a = sv[0][k];
         valid_b = sv[1][k];
         data_a  = sd[0][k];
         data_b  = sd[1][k];
         tick();
      end
      idle_in();
      chk("pre_abort_len", len_a, 3);
      new_tmpl();
      gen(0, 1, 3, -1, 1);
      gen(1, 2, 3, -1, 1);
      idx_a = 8'd1;
      idx_b = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("abort_len_a", len_a, 0);
      chk("abort_len_b", len_b, 0);
      chk("abort_busy", busy, 1);
      chk("abort_done", done, 0);
      chk("abort_ovf", ovf, 0);
      drive_run(1, 2, 0);

      // reset during compare
      new_tmpl();
      gen(0, 1, 3, -1, 1);
      gen(1, 1, 3, -1, 1);
      start_run(1, 1);
      drive_run(1, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
